ec_fe2_mnr_s: RTL and testbench



---
 rtl/ec_fe2_mnr_s.sv | 165 ++++++++++++++++
 tb/tb_ec_fe2_mnr_s.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_fe2_mnr_s.sv
// rtl/ec_fe2_mnr_s.sv - Fe2 multiply-by-non-residue responder: a*(1+u) via shared FE add/sub units
module ec_fe2_mnr_s #(
    parameter type FE_TYPE  = logic [380:0],
    parameter int  CTL_BITS = 12,
    localparam int FE       = $bits(FE_TYPE)
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_mnr_fe2_if_val,
    output logic                i_mnr_fe2_if_rdy,
    input  logic                i_mnr_fe2_if_sop,
    input  logic [FE-1:0]       i_mnr_fe2_if_dat,
    input  logic [CTL_BITS-1:0] i_mnr_fe2_if_ctl,

    output logic                o_mnr_fe2_if_val,
    input  logic                o_mnr_fe2_if_rdy,
    output logic                o_mnr_fe2_if_sop,
    output logic                o_mnr_fe2_if_eop,
    output logic                o_mnr_fe2_if_err,
    output logic                o_mnr_fe2_if_mod,
    output logic [CTL_BITS-1:0] o_mnr_fe2_if_ctl,
    output logic [FE-1:0]       o_mnr_fe2_if_dat,

    output logic                o_add_fe_if_val,
    input  logic                o_add_fe_if_rdy,
    output logic                o_add_fe_if_sop,
    output logic                o_add_fe_if_eop,
    output logic                o_add_fe_if_err,
    output logic                o_add_fe_if_mod,
    output logic [CTL_BITS-1:0] o_add_fe_if_ctl,
    output logic [2*FE-1:0]     o_add_fe_if_dat,
    input  logic                i_add_fe_if_val,
    output logic                i_add_fe_if_rdy,
    input  logic [FE-1:0]       i_add_fe_if_dat,

    output logic                o_sub_fe_if_val,
    input  logic                o_sub_fe_if_rdy,
    output logic                o_sub_fe_if_sop,
    output logic                o_sub_fe_if_eop,
    output logic                o_sub_fe_if_err,
    output logic                o_sub_fe_if_mod,
    output logic [CTL_BITS-1:0] o_sub_fe_if_ctl,
    output logic [2*FE-1:0]     o_sub_fe_if_dat,
    input  logic                i_sub_fe_if_val,
    output logic                i_sub_fe_if_rdy,
    input  logic [FE-1:0]       i_sub_fe_if_dat
);

    typedef enum logic [2:0] {IDLE, WAIT_C1, ISSUE, OUT0, OUT1} state_e;

    state_e                state_q, state_d;
    logic [FE-1:0]         c0_q, c0_d, c1_q, c1_d;
    logic [FE-1:0]         sub_res_q, sub_res_d, add_res_q, add_res_d;
    logic [CTL_BITS-1:0]   ctl_q, ctl_d;
    logic                  sub_req_done_q, sub_req_done_d, add_req_done_q, add_req_done_d;
    logic                  sub_got_q, sub_got_d, add_got_q, add_got_d;

    // Handshake signals depend only on state and flags, gated by reset so they are quiet from power-up.
    assign i_mnr_fe2_if_rdy = !i_rst && (state_q == IDLE || state_q == WAIT_C1);
    assign o_sub_fe_if_val  = !i_rst && state_q == ISSUE && !sub_req_done_q;
    assign o_add_fe_if_val  = !i_rst && state_q == ISSUE && !add_req_done_q;
    assign i_sub_fe_if_rdy  = !i_rst && state_q == ISSUE && !sub_got_q;
    assign i_add_fe_if_rdy  = !i_rst && state_q == ISSUE && !add_got_q;
    assign o_mnr_fe2_if_val = !i_rst && (state_q == OUT0 || state_q == OUT1);

    assign o_mnr_fe2_if_sop = state_q == OUT0;
    assign o_mnr_fe2_if_eop = state_q == OUT1;
    assign o_mnr_fe2_if_err = 1'b0;
    assign o_mnr_fe2_if_mod = 1'b0;
    assign o_mnr_fe2_if_ctl = ctl_q;
    assign o_mnr_fe2_if_dat = (state_q == OUT1) ? add_res_q : sub_res_q;

    assign o_sub_fe_if_sop = 1'b1;
    assign o_sub_fe_if_eop = 1'b1;
    assign o_sub_fe_if_err = 1'b0;
    assign o_sub_fe_if_mod = 1'b0;
    assign o_sub_fe_if_ctl = ctl_q;
    assign o_sub_fe_if_dat = {c1_q, c0_q};
    assign o_add_fe_if_sop = 1'b1;
    assign o_add_fe_if_eop = 1'b1;
    assign o_add_fe_if_err = 1'b0;
    assign o_add_fe_if_mod = 1'b0;
    assign o_add_fe_if_ctl = ctl_q;
    assign o_add_fe_if_dat = {c1_q, c0_q};

    always_comb begin
        state_d        = state_q;
        c0_d           = c0_q;
        c1_d           = c1_q;
        ctl_d          = ctl_q;
        sub_res_d      = sub_res_q;
        add_res_d      = add_res_q;
        sub_req_done_d = sub_req_done_q;
        add_req_done_d = add_req_done_q;
        sub_got_d      = sub_got_q;
        add_got_d      = add_got_q;
        case (state_q)
            IDLE: begin
                sub_req_done_d = 1'b0;
                add_req_done_d = 1'b0;
                sub_got_d      = 1'b0;
                add_got_d      = 1'b0;
                if (i_mnr_fe2_if_val && i_mnr_fe2_if_rdy && i_mnr_fe2_if_sop) begin
                    c0_d    = i_mnr_fe2_if_dat;
                    ctl_d   = i_mnr_fe2_if_ctl;
                    state_d = WAIT_C1;
                end
            end
            WAIT_C1: begin
                if (i_mnr_fe2_if_val && i_mnr_fe2_if_rdy) begin
                    if (i_mnr_fe2_if_sop) begin
                        c0_d  = i_mnr_fe2_if_dat;
                        ctl_d = i_mnr_fe2_if_ctl;
                    end else begin
                        c1_d    = i_mnr_fe2_if_dat;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (o_sub_fe_if_val && o_sub_fe_if_rdy) sub_req_done_d = 1'b1;
                if (o_add_fe_if_val && o_add_fe_if_rdy) add_req_done_d = 1'b1;
                if (i_sub_fe_if_val && i_sub_fe_if_rdy) begin
                    sub_res_d = i_sub_fe_if_dat;
                    sub_got_d = 1'b1;
                end
                if (i_add_fe_if_val && i_add_fe_if_rdy) begin
                    add_res_d = i_add_fe_if_dat;
                    add_got_d = 1'b1;
                end
                if (sub_got_d && add_got_d) state_d = OUT0;
            end
            OUT0: if (o_mnr_fe2_if_val && o_mnr_fe2_if_rdy) state_d = OUT1;
            OUT1: if (o_mnr_fe2_if_val && o_mnr_fe2_if_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= IDLE;
            sub_req_done_q <= 1'b0;
            add_req_done_q <= 1'b0;
            sub_got_q      <= 1'b0;
            add_got_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sub_req_done_q <= sub_req_done_d;
            add_req_done_q <= add_req_done_d;
            sub_got_q      <= sub_got_d;
            add_got_q      <= add_got_d;
        end
    end

    // Payload registers are never cleared; the flags above decide whether they are meaningful.
    always_ff @(posedge i_clk) begin
        c0_q      <= c0_d;
        c1_q      <= c1_d;
        ctl_q     <= ctl_d;
        sub_res_q <= sub_res_d;
        add_res_q <= add_res_d;
    end

endmodule

// File: tb/tb_ec_fe2_mnr_s.sv
// tb/tb_ec_fe2_mnr_s.sv - self-checking bench for ec_fe2_mnr_s with add/sub unit models
module tb_ec_fe2_mnr_s;
    localparam int FE  = 381;
    localparam int CTL = 12;
    localparam logic [FE-1:0] P = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

    logic clk = 1'b0;
    logic rst;
    logic in_val, in_rdy, in_sop;
    logic [FE-1:0] in_dat;
    logic [CTL-1:0] in_ctl;
    logic out_val, out_sop, out_eop, out_err, out_mod;
    logic out_rdy = 1'b1;
    logic [CTL-1:0] out_ctl;
    logic [FE-1:0] out_dat;
    logic add_req_val, add_req_rdy, add_req_sop, add_req_eop, add_req_err, add_req_mod;
    logic [CTL-1:0] add_req_ctl;
    logic [2*FE-1:0] add_req_dat;
    logic add_res_val = 1'b0;
    logic add_res_rdy;
    logic [FE-1:0] add_res_dat = '0;
    logic sub_req_val, sub_req_rdy, sub_req_sop, sub_req_eop, sub_req_err, sub_req_mod;
    logic [CTL-1:0] sub_req_ctl;
    logic [2*FE-1:0] sub_req_dat;
    logic sub_res_val = 1'b0;
    logic sub_res_rdy;
    logic [FE-1:0] sub_res_dat = '0;

    ec_fe2_mnr_s #(.FE_TYPE(logic [FE-1:0]), .CTL_BITS(CTL)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_mnr_fe2_if_val(in_val), .i_mnr_fe2_if_rdy(in_rdy), .i_mnr_fe2_if_sop(in_sop),
        .i_mnr_fe2_if_dat(in_dat), .i_mnr_fe2_if_ctl(in_ctl),
        .o_mnr_fe2_if_val(out_val), .o_mnr_fe2_if_rdy(out_rdy), .o_mnr_fe2_if_sop(out_sop),
        .o_mnr_fe2_if_eop(out_eop), .o_mnr_fe2_if_err(out_err), .o_mnr_fe2_if_mod(out_mod),
        .o_mnr_fe2_if_ctl(out_ctl), .o_mnr_fe2_if_dat(out_dat),
        .o_add_fe_if_val(add_req_val), .o_add_fe_if_rdy(add_req_rdy), .o_add_fe_if_sop(add_req_sop),
        .o_add_fe_if_eop(add_req_eop), .o_add_fe_if_err(add_req_err), .o_add_fe_if_mod(add_req_mod),
        .o_add_fe_if_ctl(add_req_ctl), .o_add_fe_if_dat(add_req_dat),
        .i_add_fe_if_val(add_res_val), .i_add_fe_if_rdy(add_res_rdy), .i_add_fe_if_dat(add_res_dat),
        .o_sub_fe_if_val(sub_req_val), .o_sub_fe_if_rdy(sub_req_rdy), .o_sub_fe_if_sop(sub_req_sop),
        .o_sub_fe_if_eop(sub_req_eop), .o_sub_fe_if_err(sub_req_err), .o_sub_fe_if_mod(sub_req_mod),
        .o_sub_fe_if_ctl(sub_req_ctl), .o_sub_fe_if_dat(sub_req_dat),
        .i_sub_fe_if_val(sub_res_val), .i_sub_fe_if_rdy(sub_res_rdy), .i_sub_fe_if_dat(sub_res_dat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int rc; logic [FE-1:0] d; } pend_t;
    typedef struct { logic [FE-1:0] dat; logic sop; logic eop; logic [CTL-1:0] ctl; } beat_t;
    typedef struct { logic [FE-1:0] c0; logic [FE-1:0] c1; logic [FE-1:0] e0; logic [FE-1:0] e1;
                     logic [CTL-1:0] ctl; int sl; int al; } vec_t;

    pend_t add_pq[$], sub_pq[$];
    beat_t sb[$];
    vec_t  vecs[6];
    int checks = 0, errors = 0;
    int add_lat = 3, sub_lat = 3;
    bit bp_mode = 0;
    int bp_cnt = 0;
    int out_beats = 0, exp_beats = 0;
    int rise_cyc = -1;
    bit sub_seen = 0;
    logic prev_val = 0, prev_rdy = 0, prev_sop = 0, prev_eop = 0;
    logic [CTL-1:0] prev_ctl = '0;
    logic [FE-1:0] prev_dat = '0;

    function automatic logic [FE-1:0] fadd(input logic [FE-1:0] a, input logic [FE-1:0] b);
        logic [FE:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[FE-1:0];
    endfunction

    function automatic logic [FE-1:0] fsub(input logic [FE-1:0] a, input logic [FE-1:0] b);
        logic [FE:0] s;
        s = {1'b0, a} + {1'b0, P} - {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[FE-1:0];
    endfunction

    task automatic chk(input string name, input logic [FE-1:0] act, input logic [FE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Add/sub unit models and output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            add_pq.delete();
            sub_pq.delete();
            prev_val = 0;
        end else begin
            if (sub_req_val && sub_req_rdy)
                sub_pq.push_back('{cyc + sub_lat, fsub(sub_req_dat[FE-1:0], sub_req_dat[2*FE-1:FE])});
            if (add_req_val && add_req_rdy)
                add_pq.push_back('{cyc + add_lat, fadd(add_req_dat[FE-1:0], add_req_dat[2*FE-1:FE])});
            if (sub_res_val && sub_res_rdy) begin
                void'(sub_pq.pop_front());
                sub_seen = 1;
            end
            if (add_res_val && add_res_rdy) void'(add_pq.pop_front());
            if (out_val && !prev_val) rise_cyc = cyc;
            if (prev_val && !prev_rdy)
                chk("stall_stable", {out_val, out_sop, out_eop, out_ctl, out_dat},
                    {1'b1, prev_sop, prev_eop, prev_ctl, prev_dat});
            if (bp_mode && out_val) chk("in_rdy_while_out", in_rdy, 0);
            if (out_val && out_rdy) begin
                out_beats++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", out_dat);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("out_dat", out_dat, e.dat);
                    chk("out_sop_eop_ctl_err_mod", {out_sop, out_eop, out_ctl, out_err, out_mod},
                        {e.sop, e.eop, e.ctl, 2'b00});
                end
            end
            prev_val = out_val; prev_rdy = out_rdy; prev_sop = out_sop;
            prev_eop = out_eop; prev_ctl = out_ctl; prev_dat = out_dat;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst || sub_pq.size() == 0 || sub_pq[0].rc > cyc) sub_res_val = 0;
        else begin sub_res_val = 1; sub_res_dat = sub_pq[0].d; end
        if (rst || add_pq.size() == 0 || add_pq[0].rc > cyc) add_res_val = 0;
        else begin add_res_val = 1; add_res_dat = add_pq[0].d; end
        if (bp_mode) begin
            if (out_val) begin
                if (bp_cnt < 7) begin out_rdy = 0; bp_cnt++; end
                else out_rdy = !out_rdy;
            end else out_rdy = 0;
        end else out_rdy = 1;
    end

    task automatic send_beat(input logic [FE-1:0] d, input logic sop, input logic [CTL-1:0] c, output int t);
        int n;
        n = 0;
        in_val = 1; in_dat = d; in_sop = sop; in_ctl = c;
        @(negedge clk);
        while (!in_rdy && n < 50) begin n++; @(negedge clk); end
        t = cyc;
        chk("in_accept", in_rdy, 1);
        @(posedge clk); #1;
        in_val = 0;
    endtask

    task automatic send_fe2(input logic [FE-1:0] c0, input logic [FE-1:0] c1, input logic [CTL-1:0] c, output int t0);
        int t1;
        send_beat(c0, 1'b1, c, t0);
        send_beat(c1, 1'b0, c, t1);
    endtask

    task automatic push_exp(input logic [FE-1:0] e0, input logic [FE-1:0] e1, input logic [CTL-1:0] c);
        sb.push_back('{e0, 1'b1, 1'b0, c});
        sb.push_back('{e1, 1'b0, 1'b1, c});
        exp_beats += 2;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || out_val) && n < 300) begin n++; @(negedge clk); end
        chk("drain_pending", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int t0, tb0, mx, beats0;
        rst = 1; in_val = 0; in_sop = 0; in_dat = '0; in_ctl = '0;
        add_req_rdy = 1; sub_req_rdy = 1;
        vecs[0] = '{381'd5, 381'd3, 381'd2, 381'd8, 12'hABC, 3, 3};
        vecs[1] = '{381'd3, 381'd5, P - 381'd2, 381'd8, 12'h123, 3, 3};
        vecs[2] = '{P - 381'd1, 381'd1, P - 381'd2, 381'd0, 12'h7FF, 1, 4};
        vecs[3] = '{381'd0, 381'd0, 381'd0, 381'd0, 12'h000, 2, 1};
        vecs[4] = '{P - 381'd1, P - 381'd1, 381'd0, P - 381'd2, 12'hFFF, 5, 2};
        vecs[5] = '{381'd2, P - 381'd1, 381'd3, 381'd1, 12'h5A5, 4, 4};

        repeat (3) begin
            @(negedge clk);
            chk("reset_quiet", {in_rdy, out_val, add_req_val, sub_req_val, add_res_rdy, sub_res_rdy}, 0);
        end
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rdy_after_reset", in_rdy, 1);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            sub_lat = vecs[i].sl;
            add_lat = vecs[i].al;
            mx = (vecs[i].sl > vecs[i].al) ? vecs[i].sl : vecs[i].al;
            beats0 = out_beats;
            push_exp(vecs[i].e0, vecs[i].e1, vecs[i].ctl);
            send_fe2(vecs[i].c0, vecs[i].c1, vecs[i].ctl, t0);
            wait_drain();
            chk("latency", rise_cyc, t0 + 3 + mx);
            chk("beats_per_vec", out_beats - beats0, 2);
        end

        // Out-of-order results with a stalled add request.
        sub_lat = 10; add_lat = 1; add_req_rdy = 0;
        beats0 = out_beats;
        push_exp(381'd14, 381'd26, 12'h3C3);
        send_fe2(381'd20, 381'd6, 12'h3C3, t0);
        repeat (4) begin
            @(negedge clk);
            chk("add_req_held", add_req_val, 1);
        end
        @(posedge clk); #1 add_req_rdy = 1;
        wait_drain();
        chk("ooo_beats", out_beats - beats0, 2);

        // Output backpressure.
        sub_lat = 2; add_lat = 2; bp_cnt = 0; bp_mode = 1;
        beats0 = out_beats;
        push_exp(381'd50, 381'd150, 12'h0A5);
        send_fe2(381'd100, 381'd50, 12'h0A5, t0);
        wait_drain();
        bp_mode = 0;
        chk("bp_beats", out_beats - beats0, 2);

        // Framing: stray non-sop beat, then sop resync.
        sub_lat = 3; add_lat = 3;
        push_exp(381'd3, 381'd5, 12'h333);
        send_beat(381'd77, 1'b0, 12'h111, tb0);
        send_beat(381'd9, 1'b1, 12'h222, tb0);
        send_beat(381'd4, 1'b1, 12'h333, tb0);
        send_beat(381'd1, 1'b0, 12'h333, tb0);
        wait_drain();

        // Reset while in ISSUE after the sub result has been captured.
        sub_lat = 1; add_lat = 10; sub_seen = 0;
        send_fe2(381'd30, 381'd10, 12'h055, t0);
        begin
            int n;
            n = 0;
            while (!sub_seen && n < 50) begin n++; @(negedge clk); end
        end
        chk("sub_captured_before_reset", sub_seen, 1);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("mid_reset_quiet", {in_rdy, out_val, add_req_val, sub_req_val, add_res_rdy, sub_res_rdy}, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("post_reset_idle", {in_rdy, out_val, add_req_val, sub_req_val}, 4'b1000);
        @(posedge clk); #1;
        sub_lat = 3; add_lat = 3;
        push_exp(381'd5, 381'd9, 12'h0F0);
        send_fe2(381'd7, 381'd2, 12'h0F0, t0);
        wait_drain();

        chk("total_beats", out_beats, exp_beats);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
